// File: rtl/lzd_seq_64.sv
// Sequential leading-zero counter: one 16-bit LZD is time-shared across the
// 16-bit chunks of a W-bit word, scanned from the MSB chunk downward.

// Combinational N-bit leading-zero detector; count is only meaningful for a
// nonzero input, the caller detects the all-zero case itself.
module lzd_n #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]         i_data,
  output logic [$clog2(N)-1:0] o_count
);
  localparam int unsigned CW = $clog2(N);

  logic w_hit;

  // Priority search from the MSB for the first set bit.
  always_comb begin
    w_hit   = 1'b0;
    o_count = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!w_hit && i_data[i]) begin
        o_count = CW'(N - 1 - i);
        w_hit   = 1'b1;
      end
    end
  end
endmodule

module lzd_seq_64 #(
  parameter int unsigned W         = 64,
  parameter int unsigned FIXED_LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [6:0]   out_count,
  output logic         out_zero
);
  localparam int unsigned NCH = W / 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   r_k;
  logic [W-1:0] r_data;
  logic         r_found;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [6:0]   r_out_count;
  logic         r_out_zero;

  logic [W-1:0] w_shifted;
  logic [15:0]  w_chunk;
  logic [3:0]   w_lzd;
  logic         w_nz;
  logic         w_last;
  logic [6:0]   w_cnt;

  // Bring chunk k to the top of the word so a fixed slice selects it.
  always_comb begin
    w_shifted = r_data << {r_k, 4'b0000};
    w_chunk   = w_shifted[W-1 -: 16];
    w_nz      = |w_chunk;
    w_last    = (r_k == 2'(NCH - 1));
    w_cnt     = 7'({r_k, 4'b0000}) + 7'(w_lzd);
  end

  lzd_n #(
    .N (16)
  ) u_lzd (
    .i_data  (w_chunk),
    .o_count (w_lzd)
  );

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= 2'd0;
      r_data      <= '0;
      r_found     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_count <= 7'd0;
      r_out_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data     <= in_data;
            r_k        <= 2'd0;
            r_found    <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (FIXED_LAT == 0) begin
            if (w_nz) begin
              r_out_count <= w_cnt;
              r_out_zero  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_last) begin
              r_out_count <= 7'(W);
              r_out_zero  <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_k <= r_k + 2'd1;
            end
          end else begin
            // Keep the first nonzero chunk's result; later chunks never overwrite it.
            if (w_nz && !r_found) begin
              r_out_count <= w_cnt;
              r_out_zero  <= 1'b0;
              r_found     <= 1'b1;
            end
            if (w_last) begin
              if (!r_found && !w_nz) begin
                r_out_count <= 7'(W);
                r_out_zero  <= 1'b1;
              end
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_k <= r_k + 2'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_zero  = r_out_zero;
endmodule

// File: tb/tb_lzd_seq_64.sv
// Directed bench for lzd_seq_64: early-termination and fixed-latency instances.
module tb_lzd_seq_64;
  logic        clk = 1'b0;
  logic        rst_n;
  // Early-termination instance
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [63:0] in_data;
  logic [6:0]  out_count;
  // Fixed-latency instance
  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_zero1;
  logic [63:0] in_data1;
  logic [6:0]  out_count1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lzd_seq_64 #(.W(64), .FIXED_LAT(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  lzd_seq_64 #(.W(64), .FIXED_LAT(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_count (out_count1),
    .out_zero  (out_zero1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference leading-zero count of a 64-bit word.
  function automatic int ref_lz(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) if (d[i]) return 63 - i;
    return 64;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 7'd0 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset0: rdy=%b vld=%b cnt=%0d zero=%b, required 1 0 0 0",
               in_ready, out_valid, out_count, out_zero);
    end
    n_checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || out_count1 !== 7'd0 || out_zero1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset1: rdy=%b vld=%b cnt=%0d zero=%b, required 1 0 0 0",
               in_ready1, out_valid1, out_count1, out_zero1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // One full transaction on the early-termination instance.
  task automatic run0(input logic [63:0] d, input int exp_cnt, input logic exp_zero,
                      input int exp_lat, input string name);
    int lat;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b required 1", name, in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (out_count !== 7'(exp_cnt) || out_zero !== exp_zero) begin
      n_fail++;
      $display("FAIL %s result: got cnt=%0d zero=%b required cnt=%0d zero=%b",
               name, out_count, out_zero, exp_cnt, exp_zero);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handoff: got vld=%b rdy=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  // One full transaction on the fixed-latency instance.
  task automatic run1(input logic [63:0] d, input int exp_cnt, input logic exp_zero,
                      input string name);
    int lat;
    in_valid1 = 1'b1;
    in_data1  = d;
    tick();
    in_valid1 = 1'b0;
    in_data1  = {$urandom, $urandom};
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required 4", name, lat);
    end
    n_checks++;
    if (out_count1 !== 7'(exp_cnt) || out_zero1 !== exp_zero) begin
      n_fail++;
      $display("FAIL %s result: got cnt=%0d zero=%b required cnt=%0d zero=%b",
               name, out_count1, out_zero1, exp_cnt, exp_zero);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handoff: got vld=%b rdy=%b required 0 1", name, out_valid1, in_ready1);
    end
  endtask

  task automatic test_early_term();
    run0(64'h8000_0000_0000_0000, 0, 1'b0, 1, "msb");
    run0(64'h0000_0000_0001_0000, 47, 1'b0, 3, "bit16");
    run0(64'h0000_0000_0000_0000, 64, 1'b1, 4, "zero");
    run0(64'h00F0_0000_0000_0000, 8, 1'b0, 1, "chunk0_mid");
    run0(64'h0000_0000_0000_0001, 63, 1'b0, 4, "lsb");
  endtask

  task automatic test_fixed_lat();
    run1(64'h0000_0000_0001_0000, 47, 1'b0, "fx_bit16");
    run1(64'h8000_0000_0000_0000, 0, 1'b0, "fx_msb");
    run1(64'h0000_0000_0000_0000, 64, 1'b1, "fx_zero");
    run1(64'h0100_0000_0000_0001, 7, 1'b0, "fx_keep_first");
  endtask

  task automatic test_hold();
    int lat;
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_0001_0000;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = {$urandom, $urandom};
      out_ready = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 7'd47 || out_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL hold%0d: got vld=%b rdy=%b cnt=%0d zero=%b required 1 0 47 0",
                 i, out_valid, in_ready, out_count, out_zero);
      end
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    // in_valid was high on the handoff edge; that must not have been an accept.
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_second_accept: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    in_valid = 1'b1;
    in_data  = 64'h0;
    tick();            // accept edge, now in 1st SCAN cycle
    in_valid = 1'b0;
    tick();            // now in 2nd SCAN cycle
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_count !== 7'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort: got vld=%b cnt=%0d rdy=%b required 0 0 1",
               out_valid, out_count, in_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_pulse%0d: got vld=%b required 0", i, out_valid);
      end
    end
    run0(64'h0000_FFFF_0000_0000, 16, 1'b0, 2, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [63:0] acc_q[$];
    logic [63:0] pat, exp_word;
    int idx, results, cyc;
    logic will_acc;
    idx = 0;
    results = 0;
    cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pat       = {48'h0, 16'h7FFF};
    in_data   = pat << 48;
    while (results < 4 && cyc < 200) begin
      will_acc = in_valid && in_ready;
      tick();
      cyc++;
      if (will_acc) begin
        acc_q.push_back(in_data);
        idx++;
        if (idx < 4) in_data = pat << (48 - 16 * idx);
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        results++;
        n_checks++;
        if (acc_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_dup: result %0d with no outstanding word", results);
        end else begin
          exp_word = acc_q.pop_front();
          if (out_count !== 7'(ref_lz(exp_word)) || out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: word=%h got cnt=%0d zero=%b required cnt=%0d zero=0",
                     exp_word, out_count, out_zero, ref_lz(exp_word));
          end
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) results++;
    end
    n_checks++;
    if (results !== 4 || idx !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: got results=%0d accepts=%0d required 4 4", results, idx);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    in_data1   = '0;
    out_ready1 = 1'b0;
    test_reset();
    test_early_term();
    test_fixed_lat();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lzd_seq_64.md
LZD_SEQ_64 -- requirements
Module: lzd_seq_64

Interface
REQ-001 The block SHALL have parameter W, default 64, meaning total input word width; legal values are 16, 32, 48, 64.
REQ-002 The block SHALL have parameter FIXED_LAT, default 0, meaning: 0 = early termination, 1 = always scan all chunks.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the requester presents a word.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept a word this cycle.
REQ-007 The block SHALL have port in_data, input, W, meaning the word to count; bit W-1 is the MSB.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 The block SHALL have port out_count, output, 7, meaning leading-zero count, range 0..W.
REQ-011 The block SHALL have port out_zero, output, 1, meaning in_data was all zeros.

Function
REQ-012 The block SHALL use exactly one 16-bit LZD_N instance (N=16) as its only leading-zero datapath, time-shared across chunks.
REQ-013 The block SHALL implement FSM states IDLE, SCAN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 When in_valid and in_ready are both 1 at a rising edge, the block SHALL register in_data, set chunk index k=0, and enter SCAN.
REQ-016 Each SCAN cycle SHALL examine chunk k, which is bits [W-1-16k : W-16-16k], starting from the MSB chunk.
REQ-017 If FIXED_LAT=0 and chunk k is nonzero, the block SHALL latch out_count = 16k + LZD(chunk k) and out_zero=0, then enter DONE.
REQ-018 If chunk k is zero and k < W/16-1, the block SHALL increment k and remain in SCAN.
REQ-019 If chunk k is zero and k = W/16-1, the block SHALL latch out_count=W and out_zero=1, then enter DONE.
REQ-020 If FIXED_LAT=1, the block SHALL latch the result from the first nonzero chunk, keep it, keep scanning until k=W/16-1, and only then enter DONE.
REQ-021 The block SHALL detect a zero chunk with its own OR reduction and SHALL NOT use the LZD output when the chunk is zero.
REQ-022 Latency, FIXED_LAT=0: out_valid SHALL rise f+1 cycles after the accept edge, where f is the index of the first nonzero chunk; for all-zero input it SHALL rise W/16 cycles after the accept edge.
REQ-023 Latency, FIXED_LAT=1: out_valid SHALL rise W/16 cycles after the accept edge for every input.
REQ-024 In DONE, out_valid SHALL be 1, and out_count and out_zero SHALL hold stable until out_valid and out_ready are both 1 at a rising edge.
REQ-025 On that out_valid/out_ready edge, the block SHALL enter IDLE; it SHALL NOT accept a new word in the same cycle as result handoff.
REQ-026 in_ready SHALL be 0 in SCAN and DONE, and in_data changes in those states SHALL have no effect.
REQ-027 in_ready, out_valid, out_count and out_zero SHALL all be registered outputs.
REQ-028 The block SHALL ignore out_ready when out_valid is 0.

Reset
REQ-029 While rst_n=0 at a rising edge, the next state SHALL be IDLE with k=0, in_ready=1, out_valid=0, out_count=0 and out_zero=0.
REQ-030 Reset asserted in SCAN or DONE SHALL abort the operation, discard the result and produce no out_valid pulse.
REQ-031 After reset is released, the first accept SHALL behave exactly as it does from power-up.

Verification
REQ-032 in_data=64'h8000_0000_0000_0000, FIXED_LAT=0 -> out_valid 1 cycle after accept; out_count=0, out_zero=0.
REQ-033 in_data=64'h0000_0000_0001_0000 -> out_count=47, out_zero=0, out_valid 3 cycles after accept; with FIXED_LAT=1 -> same values, 4 cycles after accept.
REQ-034 in_data=0 -> out_count=64, out_zero=1, out_valid 4 cycles after accept.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/in_data -> outputs stable, in_ready=0, no second accept; raise out_ready -> IDLE next cycle, in_ready=1.
REQ-036 Assert rst_n=0 in the 2nd SCAN cycle of in_data=0 -> next cycle IDLE, out_valid=0, out_count=0; a later accept of 64'h0000_FFFF_0000_0000 -> out_count=16.
REQ-037 Rotate the 16-bit pattern 0111_1111_1111_1111 through each chunk position in a back-to-back stream -> every out_count matches a reference model, and no result is dropped or duplicated.
